// File: rtl/sipo_capture_controller_pkg.sv
// Shared definitions for the serial-in/parallel-out capture controller:
// state encoding, default word width and a counter-width helper.
package sipo_capture_controller_pkg;

  localparam int unsigned SIPO_WIDTH_DEFAULT = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter width; a 1-bit counter is kept for degenerate widths.
  function automatic int unsigned cnt_width(input int unsigned w);
    if (w > 32'd1) begin
      return $clog2(w);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/sipo_shift_chain.sv
// Enable-gated shift chain. New bits enter at the MSB and the chain moves
// toward bit 0, so after WIDTH enabled clocks the first bit sits in q[0].
module sipo_shift_chain
  import sipo_capture_controller_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             b,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_r;

  // Shift register: clear on reset, shift b in at the MSB when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= {WIDTH{1'b0}};
    end else if (en) begin
      chain_r <= {b, chain_r[WIDTH-1:1]};
    end else begin
      chain_r <= chain_r;
    end
  end

  assign q = chain_r;

endmodule

// File: rtl/sipo_capture_controller.sv
// Capture controller: a start strobe opens a frame, the shift chain is
// enabled for exactly WIDTH clocks, then the word moves into a holding
// register presented with a valid/ready handshake. A completed word that
// finds the holding register still full is dropped and flagged as overrun.
module sipo_capture_controller
  import sipo_capture_controller_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             b,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  state_t           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] hold_r, hold_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             ovr_r, ovr_nxt_s;
  logic             busy_r;
  logic             shift_en_s;
  logic [WIDTH-1:0] chain_s;

  assign shift_en_s = (state_r == ST_SHIFT);

  sipo_shift_chain #(
    .WIDTH (WIDTH)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .en  (shift_en_s),
    .b   (b),
    .q   (chain_s)
  );

  // State and datapath registers; busy is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      hold_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      hold_r  <= hold_nxt_s;
      valid_r <= valid_nxt_s;
      ovr_r   <= ovr_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state, counter, handshake and overrun logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    hold_nxt_s  = hold_r;
    valid_nxt_s = valid_r;
    ovr_nxt_s   = ovr_r;

    // Consumer takes the held word; a DONE transfer below may re-assert valid.
    if (valid_r && out_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end

    // Clear is applied first so that a same-edge overrun set wins.
    if (clr_overrun) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = ovr_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SHIFT;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_SHIFT;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        if (!valid_r || out_ready) begin
          hold_nxt_s  = chain_s;
          valid_nxt_s = 1'b1;
        end else begin
          ovr_nxt_s   = 1'b1;
        end
        cnt_nxt_s = CNT_ZERO;
        if (start) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign q         = hold_r;
  assign overrun   = ovr_r;

endmodule

// File: tb/tb_sipo_capture_controller.sv
// Directed testbench for sipo_capture_controller with WIDTH=4.
module tb_sipo_capture_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       b;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q;
  logic       overrun;
  logic       clr_overrun;

  int tests_run;
  int tests_failed;

  sipo_capture_controller #(
    .WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .b           (b),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start strobe then four bits, bits[0] first. Leaves the FSM in DONE.
  task automatic send_frame(input logic [3:0] bits);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = bits[i];
      step();
    end
    b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++; if (q !== 4'b0000) begin tests_failed++; $display("FAIL reset_q cyc%0d got %b want %b", i, q, 4'b0000); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid cyc%0d got %b want 0", i, out_valid); end
      tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun cyc%0d got %b want 0", i, overrun); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy cyc%0d got %b want 0", i, busy); end
    end
    rst = 1'b0; start = 1'b0; b = 1'b0;
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    out_ready = 1'b0;
    send_frame(4'b1101);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL frame_busy_done got %b want 1", busy); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL frame_valid_early got %b want 0", out_valid); end
    step();
    tests_run++; if (q !== 4'b1101) begin tests_failed++; $display("FAIL frame_q got %b want %b", q, 4'b1101); end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL frame_valid got %b want 1", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL frame_busy_after got %b want 0", busy); end
    step();
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL frame_valid_hold got %b want 1", out_valid); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_frame(4'b1000);
    step();
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set got %b want 1", overrun); end
    tests_run++; if (q !== 4'b1101) begin tests_failed++; $display("FAIL ovr_q_kept got %b want %b", q, 4'b1101); end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid got %b want 1", out_valid); end
    step();
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_frame(4'b1111);
    start = 1'b1;
    step();
    start = 1'b0;
    tests_run++; if (q !== 4'b1111) begin tests_failed++; $display("FAIL b2b_q1 got %b want %b", q, 4'b1111); end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid1 got %b want 1", out_valid); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy got %b want 1", busy); end
    b = 1'b0; step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_consumed got %b want 0", out_valid); end
    tests_run++; if (q !== 4'b1111) begin tests_failed++; $display("FAIL b2b_q_hold got %b want %b", q, 4'b1111); end
    b = 1'b1; step();
    b = 1'b0; step();
    b = 1'b1; step();
    b = 1'b0;
    tests_run++; if (q !== 4'b1111) begin tests_failed++; $display("FAIL b2b_q_before got %b want %b", q, 4'b1111); end
    step();
    tests_run++; if (q !== 4'b1010) begin tests_failed++; $display("FAIL b2b_q2 got %b want %b", q, 4'b1010); end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid2 got %b want 1", out_valid); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_final_consume got %b want 0", out_valid); end
    tests_run++; if (q !== 4'b1010) begin tests_failed++; $display("FAIL b2b_q_after got %b want %b", q, 4'b1010); end
    out_ready = 1'b0;
  endtask

  task automatic test_same_edge();
    out_ready = 1'b0;
    send_frame(4'b0001);
    step();
    tests_run++; if (q !== 4'b0001) begin tests_failed++; $display("FAIL same_qa got %b want %b", q, 4'b0001); end
    send_frame(4'b1100);
    out_ready = 1'b1;
    step();
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL same_valid got %b want 1", out_valid); end
    tests_run++; if (q !== 4'b1100) begin tests_failed++; $display("FAIL same_qb got %b want %b", q, 4'b1100); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL same_overrun got %b want 0", overrun); end
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL same_consume got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    start = 1'b1; step();
    start = 1'b0;
    b = 1'b1; step();
    b = 1'b1; step();
    rst = 1'b1; b = 1'b0;
    step();
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b want 0", busy); end
    tests_run++; if (q !== 4'b0000) begin tests_failed++; $display("FAIL mid_q got %b want %b", q, 4'b0000); end
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_idle got %b want 0", busy); end
    send_frame(4'b0110);
    step();
    tests_run++; if (q !== 4'b0110) begin tests_failed++; $display("FAIL mid_newq got %b want %b", q, 4'b0110); end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_valid got %b want 1", out_valid); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL mid_overrun got %b want 0", overrun); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; start = 1'b0; b = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
    test_reset();
    test_single_frame();
    test_overrun();
    test_back_to_back();
    test_same_edge();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
